// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Request/response handshake between the datapath and the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store initiator for a big-endian,
//               byte-addressed, word-wide data memory (RMW for sub-word stores).
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  wire                 clk,
    input  wire                 reset,
    load_store_unit_if.slave    bus,
    output logic [31:0]         mem_address,
    output logic [31:0]         mem_write_data,
    output logic                mem_memwrite,
    input  wire  [31:0]         mem_read_data
);

    localparam logic [1:0]  SIZE_BYTE = 2'b00;
    localparam logic [1:0]  SIZE_HALF = 2'b01;
    localparam logic [1:0]  SIZE_WORD = 2'b10;
    localparam logic [1:0]  SIZE_BAD  = 2'b11;
    localparam logic [32:0] LAST_BYTE = 33'(MEM_BYTES) - 33'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        unsigned_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] word_q;

    logic        accept;
    logic        req_error;
    logic [32:0] top_byte;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign accept = (state == IDLE) && bus.req_valid;

    // Highest byte touched by the aligned word; 33 bits so the top of the
    // address space cannot wrap into range.
    assign top_byte  = {1'b0, bus.req_addr[31:2], 2'b11};
    assign req_error = (bus.req_size == SIZE_BAD)
                    || ((bus.req_size == SIZE_HALF) && bus.req_addr[0])
                    || ((bus.req_size == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00))
                    || (top_byte > LAST_BYTE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_error) begin
                        state_next = RESP;
                    end else if (bus.req_write && (bus.req_size == SIZE_WORD)) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD:      state_next = write_q ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= 32'd0;
            size_q     <= 2'd0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            word_q     <= 32'd0;
        end else begin
            if (accept) begin
                addr_q     <= bus.req_addr;
                size_q     <= bus.req_size;
                write_q    <= bus.req_write;
                unsigned_q <= bus.req_unsigned;
                wdata_q    <= bus.req_wdata;
                err_q      <= req_error;
            end
            if (state == RD) begin
                word_q <= mem_read_data;
            end
        end
    end

    // Big-endian lane select: byte offset 0 lives in the most significant lane.
    always_comb begin
        lane_byte = 8'h00;
        case (addr_q[1:0])
            2'd0:    lane_byte = word_q[31:24];
            2'd1:    lane_byte = word_q[23:16];
            2'd2:    lane_byte = word_q[15:8];
            default: lane_byte = word_q[7:0];
        endcase
        lane_half = addr_q[1] ? word_q[15:0] : word_q[31:16];

        load_data = word_q;
        case (size_q)
            SIZE_BYTE: load_data = unsigned_q ? {24'h000000, lane_byte}
                                              : {{24{lane_byte[7]}}, lane_byte};
            SIZE_HALF: load_data = unsigned_q ? {16'h0000, lane_half}
                                              : {{16{lane_half[15]}}, lane_half};
            default:   load_data = word_q;
        endcase
    end

    always_comb begin
        merged_word = word_q;
        case (size_q)
            SIZE_BYTE: begin
                case (addr_q[1:0])
                    2'd0:    merged_word[31:24] = wdata_q[7:0];
                    2'd1:    merged_word[23:16] = wdata_q[7:0];
                    2'd2:    merged_word[15:8]  = wdata_q[7:0];
                    default: merged_word[7:0]   = wdata_q[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (addr_q[1]) begin
                    merged_word[15:0] = wdata_q[15:0];
                end else begin
                    merged_word[31:16] = wdata_q[15:0];
                end
            end
            default: merged_word = word_q;
        endcase
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_error = (state == RESP) && err_q;
    assign bus.resp_rdata = ((state == RESP) && !err_q && !write_q) ? load_data : 32'd0;

    assign mem_memwrite   = (state == WR);
    assign mem_address    = ((state == RD) || (state == WR)) ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_write_data = (state == WR) ? ((size_q == SIZE_WORD) ? wdata_q : merged_word)
                                          : 32'd0;

endmodule
`default_nettype wire
